// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the ID->EX decode/control stage.
// Pure definitions: no timing and no handshake of its own.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_BR  = 2'b01;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       upper_imm;
        logic       auipc;
        logic       pc_sel;
        logic       pc_return;
        logic       jump;
        logic       illegal;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode -> control bundle decoder; purely combinational, zero latency, no handshake.
// Unknown opcodes yield a bundle with only the illegal flag set.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_opcode)
            OPC_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_OP_R;
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.uses_rs2  = 1'b1;
            end
            OPC_I_ALU: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_OP_I;
                w_ctrl.uses_rs1  = 1'b1;
            end
            OPC_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALU_OP_ADD;
                w_ctrl.uses_rs1   = 1'b1;
            end
            OPC_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_OP_ADD;
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.uses_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                w_ctrl.branch   = 1'b1;
                w_ctrl.alu_op   = ALU_OP_BR;
                w_ctrl.uses_rs1 = 1'b1;
                w_ctrl.uses_rs2 = 1'b1;
            end
            OPC_LUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.upper_imm = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.auipc     = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.pc_sel    = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.pc_sel    = 1'b1;
                w_ctrl.pc_return = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.uses_rs1  = 1'b1;
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/control_stage.sv
// ID->EX pipeline register with decode, load-use bubble insertion, flush and saturating counters.
// Latency 1 cycle, 1/cycle throughput; out_* held while out_valid & ~out_ready, in_ready drops.
module control_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int CNT_W          = 16,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output ctrl_t            out_ctrl,
    output logic             hazard_o,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] illegal_count
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [31:0]      r_instr;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;

    ctrl_t            w_dec;
    logic             w_hazard;
    logic             w_in_ready;
    logic             w_load;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;

    ctrl_decode u_decode (
        .i_opcode (in_instr[6:0]),
        .o_ctrl   (w_dec)
    );

    assign w_rd  = r_instr[11:7];
    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];

    // The held load's rd is compared against the sources the incoming opcode actually reads.
    generate
        if (LOAD_USE_STALL) begin : g_hazard
            assign w_hazard = r_valid & r_ctrl.mem_read & (w_rd != 5'd0) & in_valid
                            & ((w_dec.uses_rs1 & (w_rs1 == w_rd))
                             | (w_dec.uses_rs2 & (w_rs2 == w_rd)));
        end else begin : g_no_hazard
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign w_in_ready = (~r_valid | out_ready) & ~w_hazard & ~flush;
    assign w_load     = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_instr       <= '0;
            r_ctrl        <= '0;
            r_stall_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_pc    <= in_pc;
            r_instr <= in_instr;
            r_ctrl  <= w_dec;
            if (w_dec.illegal && (r_illegal_cnt != {CNT_W{1'b1}}))
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end else if (out_ready) begin
            // Drain without refill; a pending hazard makes this the inserted bubble.
            r_valid <= 1'b0;
            if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_instr     = r_instr;
    assign out_ctrl      = r_ctrl;
    assign hazard_o      = w_hazard;
    assign stall_count   = r_stall_cnt;
    assign illegal_count = r_illegal_cnt;

endmodule
